// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous memory port between two requesters:
//   requester 0 : CPU data path
//   requester 1 : secondary master (video / DMA)
//
// At most one access is granted per cycle. Ties are broken round-robin. A
// requester may hold the port for an atomic sequence by asserting its lock
// input. The lock is bounded: after LOCK_MAX consecutive locked grants, a
// waiting requester gets one access in between. Read responses are tagged, so
// each requester's rvalid qualifies the shared rdata one cycle after acceptance.
//
// Ports
//   c                  clock; all state updates on the rising edge
//   r                  asynchronous active-low reset
//   reqN / weN / lockN request, write enable (1 = write), keep-ownership hint
//   addrN / wdataN     access address and write data, held until granted
//   gntN               combinational grant; accepted on an edge with reqN && gntN
//   rvalidN            read data on rdata belongs to requester N this cycle
//   rdata              shared read data (pass-through of mem_rdata)
//   mem_addr / mem_we / mem_wdata / mem_rdata
//                      synchronous RAM port; read data one cycle after address
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int LOCK_MAX   = 8
) (
   input  logic                  c,
   input  logic                  r,

   input  logic                  req0,
   input  logic                  we0,
   input  logic                  lock0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,

   input  logic                  req1,
   input  logic                  we1,
   input  logic                  lock1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,

   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,

   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // Counter wide enough to hold 0..LOCK_MAX.
   localparam int                CNT_W      = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0]  LOCK_MAX_C = CNT_W'(LOCK_MAX);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic             last;        // requester granted most recently
   logic             locked_q;    // a lock sequence is active
   logic             lock_owner;  // requester that owns the lock
   logic [CNT_W-1:0] lock_cnt;    // consecutive locked grants in current run
   logic             rd_pend;     // a read was accepted on the previous edge
   logic             rd_owner;    // requester that read belongs to

   // ---------------------------------------------------------------------------
   // Grant selection
   // ---------------------------------------------------------------------------
   logic owner_req;     // lock owner is requesting
   logic owner_lock;    // lock owner still asks to keep the port
   logic other_req;     // the non-owner is requesting
   logic lock_hold;     // lock sequence survives this cycle (no release)
   logic lock_force;    // lock owner wins regardless of round-robin
   logic gnt_any;       // some requester is granted this cycle
   logic gnt_sel;       // which one (valid when gnt_any)
   logic acc_we;        // write enable of the granted requester
   logic acc_lock;      // lock input of the granted requester

   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      owner_req  = lock_owner ? req1  : req0;
      owner_lock = lock_owner ? lock1 : lock0;
      other_req  = lock_owner ? req0  : req1;

      lock_hold  = locked_q && owner_req && owner_lock;
      // Once the run reaches LOCK_MAX the owner only keeps winning while the
      // other side is idle; otherwise round-robin hands the port over.
      lock_force = lock_hold && ((lock_cnt < LOCK_MAX_C) || !other_req);

      gnt_any = 1'b0;
      gnt_sel = 1'b0;
      if (!r) begin
         // Nothing is granted while reset is asserted.
         gnt_any = 1'b0;
      end else if (lock_force) begin
         gnt_any = 1'b1;
         gnt_sel = lock_owner;
      end else if (req0 && req1) begin
         gnt_any = 1'b1;
         gnt_sel = ~last;
      end else if (req0) begin
         gnt_any = 1'b1;
         gnt_sel = 1'b0;
      end else if (req1) begin
         gnt_any = 1'b1;
         gnt_sel = 1'b1;
      end

      acc_we   = gnt_sel ? we1   : we0;
      acc_lock = gnt_sel ? lock1 : lock0;
   end

   assign gnt0 = gnt_any && !gnt_sel;
   assign gnt1 = gnt_any &&  gnt_sel;

   // ---------------------------------------------------------------------------
   // Memory side: requester 0 drives address/data whenever nobody is granted,
   // which keeps the mux a single select bit.
   // ---------------------------------------------------------------------------
   assign mem_addr  = gnt1 ? addr1  : addr0;
   assign mem_wdata = gnt1 ? wdata1 : wdata0;
   assign mem_we    = gnt_any && acc_we;

   // ---------------------------------------------------------------------------
   // Read response: RAM data arrives one cycle after the address, so the tag
   // registered at acceptance lines up with mem_rdata on the following cycle.
   // ---------------------------------------------------------------------------
   assign rvalid0 = rd_pend && !rd_owner;
   assign rvalid1 = rd_pend &&  rd_owner;
   assign rdata   = mem_rdata;

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         // NOTE: all state uses non-blocking assignments, so every update here
         // sees the pre-edge values regardless of statement order; later
         // assignments to the same register simply take priority.
         last       <= 1'b1;   // requester 0 wins the first tie
         locked_q   <= 1'b0;
         lock_owner <= 1'b0;
         lock_cnt   <= '0;
         rd_pend    <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         // One response per accepted read; writes and idle cycles clear it.
         rd_pend <= gnt_any && !acc_we;

         if (gnt_any) begin
            last <= gnt_sel;
            if (!acc_we) begin
               rd_owner <= gnt_sel;
            end
         end

         // Release: owner stopped requesting or dropped its lock.
         if (locked_q && !lock_hold) begin
            locked_q <= 1'b0;
            lock_cnt <= '0;
         end

         if (gnt_any) begin
            if (lock_hold) begin
               if (gnt_sel == lock_owner) begin
                  // Continue the run, saturating at LOCK_MAX.
                  if (lock_cnt < LOCK_MAX_C) begin
                     lock_cnt <= lock_cnt + 1'b1;
                  end
               end else begin
                  // Forced break: the waiting side got its slot. The lock
                  // stays with the owner and a fresh run starts on its next
                  // grant.
                  lock_cnt <= '0;
               end
            end else if (acc_lock) begin
               // Acquire (also covers taking over right after a release).
               locked_q   <= 1'b1;
               lock_owner <= gnt_sel;
               lock_cnt   <= CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives directed scenarios followed by randomized traffic into
// mem_port_arbiter, with a small synchronous write-first RAM attached to the
// memory port. A behavioural model (winner history, lock holder and run
// length, shadow memory contents) predicts grants, the memory-side drive and
// each read response.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int LM = 8;

   logic          c = 1'b0;
   logic          r;
   logic          req0, we0, lock0, req1, we1, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   mem_port_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LOCK_MAX   (LM)
   ) dut (
      .c         (c),
      .r         (r),
      .req0      (req0),
      .we0       (we0),
      .lock0     (lock0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .req1      (req1),
      .we1       (we1),
      .lock1     (lock1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 c = ~c;

   // ---------------------------------------------------------------------------
   // Synchronous write-first RAM (256 words); unwritten words read a pattern.
   // ---------------------------------------------------------------------------
   function automatic logic [DW-1:0] init_word(input int a);
      return DW'((a * 16'h0101) ^ 16'h5A3C);
   endfunction

   logic [DW-1:0] ram [256];
   logic [255:0]  written = '0;

   always @(posedge c) begin
      if (mem_we) begin
         ram[mem_addr[7:0]]     <= mem_wdata;
         written[mem_addr[7:0]] <= 1'b1;
         mem_rdata              <= mem_wdata;
      end else begin
         mem_rdata <= written[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_word(int'(mem_addr[7:0]));
      end
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int            m_last;       // last winner (0/1)
   int            m_holder;     // lock holder, -1 when nobody holds the lock
   int            m_streak;     // locked grants in the current run
   bit            m_rv;         // a read response is due now
   int            m_rv_owner;
   logic [DW-1:0] m_rv_data;
   logic [DW-1:0] shadow [256];

   function automatic logic rq(input int i);  return (i == 0) ? req0  : req1;  endfunction
   function automatic logic lk(input int i);  return (i == 0) ? lock0 : lock1; endfunction
   function automatic logic wev(input int i); return (i == 0) ? we0   : we1;   endfunction
   function automatic logic [AW-1:0] av(input int i); return (i == 0) ? addr0 : addr1; endfunction
   function automatic logic [DW-1:0] dv(input int i); return (i == 0) ? wdata0 : wdata1; endfunction

   task automatic model_reset();
      m_last   = 1;
      m_holder = -1;
      m_streak = 0;
      m_rv     = 0;
   endtask

   // Returns the requester that should own the port now, or -1.
   function automatic int model_grant();
      if (!r) return -1;
      if (m_holder >= 0 && rq(m_holder) && lk(m_holder) &&
          (m_streak < LM || !rq(1 - m_holder)))
         return m_holder;
      if (rq(0) && rq(1)) return 1 - m_last;
      if (rq(0)) return 0;
      if (rq(1)) return 1;
      return -1;
   endfunction

   task automatic model_edge(input int g);
      m_rv = 0;
      if (m_holder >= 0 && (!rq(m_holder) || !lk(m_holder))) begin
         m_holder = -1;
         m_streak = 0;
      end
      if (g >= 0) begin
         m_last = g;
         if (m_holder >= 0)
            m_streak = (g == m_holder) ? ((m_streak < LM) ? m_streak + 1 : LM) : 0;
         else if (lk(g)) begin
            m_holder = g;
            m_streak = 1;
         end
         if (wev(g))
            shadow[av(g) % 256] = dv(g);
         else begin
            m_rv       = 1;
            m_rv_owner = g;
            m_rv_data  = shadow[av(g) % 256];
         end
      end
   endtask

   task automatic check_outputs(input int g);
      check("gnt", 32'({gnt1, gnt0}), (g < 0) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2));
      if (g >= 0) begin
         check("mem_addr", 32'(mem_addr), 32'(av(g)));
         check("mem_we", 32'(mem_we), 32'(wev(g)));
         if (wev(g)) check("mem_wdata", 32'(mem_wdata), 32'(dv(g)));
      end else begin
         check("mem_we_idle", 32'(mem_we), 32'd0);
      end
      check("rvalid", 32'({rvalid1, rvalid0}), m_rv ? ((m_rv_owner == 0) ? 32'd1 : 32'd2) : 32'd0);
      if (m_rv) check("rdata", 32'(rdata), 32'(m_rv_data));
   endtask

   // One clock cycle: inputs are already set (at the falling edge); check
   // shortly after, let the rising edge happen, advance the model, and return
   // at the next falling edge. g is the winner of this cycle.
   task automatic cycle(output int g);
      #1;
      g = model_grant();
      check_outputs(g);
      @(posedge c);
      if (!r) model_reset();
      else    model_edge(g);
      @(negedge c);
   endtask

   task automatic set0(input logic rq_i, input logic we_i, input logic lk_i,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      req0 = rq_i; we0 = we_i; lock0 = lk_i; addr0 = a; wdata0 = d;
   endtask

   task automatic set1(input logic rq_i, input logic we_i, input logic lk_i,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      req1 = rq_i; we1 = we_i; lock1 = lk_i; addr1 = a; wdata1 = d;
   endtask

   task automatic do_reset();
      int g;
      set0(1'b0, 1'b0, 1'b0, '0, '0);
      set1(1'b0, 1'b0, 1'b0, '0, '0);
      r = 1'b0;
      model_reset();
      cycle(g);
      r = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int g;
      int seq [20];
      int run;

      for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
      model_reset();

      // Reset held with both requesting (requester 0 writing).
      r = 1'b0;
      set0(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1111);
      set1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h2222);
      #1;
      check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      cycle(g);
      cycle(g);
      r = 1'b1;
      cycle(g);
      check("rst_first_winner", 32'(g), 32'd0);
      set0(1'b0, 1'b0, 1'b0, '0, '0);
      set1(1'b0, 1'b0, 1'b0, '0, '0);
      cycle(g);

      // Round-robin between two readers.
      do_reset();
      set0(1'b1, 1'b0, 1'b0, 16'h0010, '0);
      set1(1'b1, 1'b0, 1'b0, 16'h0020, '0);
      for (int i = 0; i < 4; i++) begin
         cycle(g);
         check("rr_order", 32'(g), 32'(i % 2));
      end
      set0(1'b0, 1'b0, 1'b0, '0, '0);
      set1(1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("rr_last_rvalid1", 32'(rvalid1), 32'd1);
      check("rr_last_rdata", 32'(rdata), 32'(init_word(16'h0020)));
      cycle(g);

      // Single requester: write then read back.
      set1(1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
      #1;
      check("single_mem_addr", 32'(mem_addr), 32'h0040);
      check("single_mem_we", 32'(mem_we), 32'd1);
      cycle(g);
      check("single_rvalid_after_write", 32'({rvalid1, rvalid0}), 32'd0);
      set1(1'b1, 1'b0, 1'b0, 16'h0040, '0);
      cycle(g);
      set1(1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("single_read_rvalid1", 32'(rvalid1), 32'd1);
      check("single_read_rdata", 32'(rdata), 32'hBEEF);
      cycle(g);

      // Lock within limit: LOCK_MAX grants to 0, one to 1, then 0 again.
      do_reset();
      set0(1'b1, 1'b0, 1'b1, 16'h0003, '0);
      set1(1'b1, 1'b0, 1'b0, 16'h0004, '0);
      for (int i = 0; i < 20; i++) begin
         cycle(g);
         seq[i] = g;
      end
      run = 0;
      while (run < 20 && seq[run] == 0) run++;
      check("lock_run_len", 32'(run), 32'(LM));
      check("lock_break_winner", 32'(seq[LM]), 32'd1);
      check("lock_resume_winner", 32'(seq[LM + 1]), 32'd0);

      // Lock release after three locked grants.
      do_reset();
      set0(1'b1, 1'b0, 1'b1, 16'h0005, '0);
      set1(1'b1, 1'b0, 1'b0, 16'h0006, '0);
      for (int i = 0; i < 3; i++) begin
         cycle(g);
         check("lrel_locked_winner", 32'(g), 32'd0);
      end
      lock0 = 1'b0;
      cycle(g);
      check("lrel_next_winner", 32'(g), 32'd1);
      cycle(g);
      check("lrel_after_winner", 32'(g), 32'd0);

      // Reset mid-read.
      do_reset();
      set0(1'b1, 1'b0, 1'b0, 16'h0007, '0);
      set1(1'b0, 1'b0, 1'b0, '0, '0);
      cycle(g);
      set0(1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("midrd_rvalid0_before", 32'(rvalid0), 32'd1);
      r = 1'b0;
      model_reset();
      #1;
      check("midrd_rvalid0_cleared", 32'(rvalid0), 32'd0);
      @(negedge c);
      r = 1'b1;
      cycle(g);
      cycle(g);
      check("midrd_no_stale", 32'({rvalid1, rvalid0}), 32'd0);

      // Randomized traffic; a requester not granted holds its request.
      do_reset();
      g = -1;
      for (int i = 0; i < 3000; i++) begin
         if (!(req0 && g != 0)) begin
            req0   = ($urandom_range(0, 9) < 7);
            we0    = 1'($urandom_range(0, 1));
            addr0  = AW'($urandom_range(0, 15));
            wdata0 = DW'($urandom);
            if ($urandom_range(0, 3) == 0) lock0 = 1'($urandom_range(0, 1));
         end
         if (!(req1 && g != 1)) begin
            req1   = ($urandom_range(0, 9) < 7);
            we1    = 1'($urandom_range(0, 1));
            addr1  = AW'($urandom_range(0, 15));
            wdata1 = DW'($urandom);
            if ($urandom_range(0, 3) == 0) lock1 = 1'($urandom_range(0, 1));
         end
         cycle(g);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
